// File: rtl/jk_input_cond.sv
// Debounced two-channel set/clear conditioner feeding a J/K Moore FSM.
// Define JK_PULSE_OUT_EN for one-cycle j/k pulses on debounced rises instead of levels.
module jk_input_cond #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_on,
    input  logic btn_off,
    output logic j,
    output logic k,
    output logic conflict
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Bit 0 is the set (on) channel, bit 1 is the clear (off) channel.
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       db;
    logic [CNT_W-1:0] cnt [2];

    assign raw = {btn_off, btn_on};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef JK_PULSE_OUT_EN
    logic [1:0] db_q;

    // A pulse fires only on the edge after a channel's rise, and only if the other channel is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q     <= '0;
            j        <= 1'b0;
            k        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            db_q     <= db;
            j        <= db[0] & ~db_q[0] & ~db[1];
            k        <= db[1] & ~db_q[1] & ~db[0];
            conflict <= db[0] & db[1];
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            j        <= 1'b0;
            k        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            j        <= db[0] & ~db[1];
            k        <= db[1] & ~db[0];
            conflict <= db[0] & db[1];
        end
    end
`endif

endmodule

// File: tb/tb_jk_input_cond.sv
// Scoreboard bench for jk_input_cond: history-window reference model plus directed latency cases.
// Honours JK_PULSE_OUT_EN the same way as the design.
module tb_jk_input_cond;

    localparam int unsigned DB = 4;

    logic clk;
    logic reset;
    logic btn_on;
    logic btn_off;
    logic j;
    logic k;
    logic conflict;

    int checks = 0;
    int errors = 0;

    jk_input_cond #(.DB_CYCLES(DB), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_on   (btn_on),
        .btn_off  (btn_off),
        .j        (j),
        .k        (k),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: raw samples taken on each post-reset edge. A channel's level flips once the
    // DB most recent synchronised samples (raw delayed two edges) all disagree with it.
    bit hon[$];
    bit hoff[$];
    bit m_on, m_off, p_on, p_off;
    logic [2:0] exp_q[$];

    function automatic bit accept(input bit h[$], input bit cur);
        int idx;
        bit v;
        for (int i = 0; i < int'(DB); i++) begin
            idx = int'(h.size()) - 2 - i;
            v = (idx >= 0) ? h[idx] : 1'b0;
            if (v == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        bit n_on, n_off;
        logic [2:0] e;
        if (!reset) begin
            hon.delete();
            hoff.delete();
            m_on = 0; m_off = 0; p_on = 0; p_off = 0;
        end else begin
`ifdef JK_PULSE_OUT_EN
            e = {m_on & !p_on & !m_off, m_off & !p_off & !m_on, m_on & m_off};
`else
            e = {m_on & !m_off, m_off & !m_on, m_on & m_off};
`endif
            exp_q.push_back(e);
            n_on  = accept(hon, m_on)   ? !m_on  : m_on;
            n_off = accept(hoff, m_off) ? !m_off : m_off;
            p_on = m_on; p_off = m_off;
            m_on = n_on; m_off = n_off;
            hon.push_back(btn_on);
            hoff.push_back(btn_off);
            if (hon.size() > DB + 4) void'(hon.pop_front());
            if (hoff.size() > DB + 4) void'(hoff.pop_front());
        end
    end

    // Monitor: outputs are presented every cycle; during reset they must read zero.
    always @(negedge clk) begin
        logic [2:0] e;
        if (!reset) begin
            exp_q.delete();
            check("reset_outputs", int'({j, k, conflict}), 0);
        end else if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("scoreboard_jkc", int'({j, k, conflict}), int'(e));
        end
    end

    function automatic logic out_sel(input int sel);
        case (sel)
            0: return j;
            1: return k;
            default: return conflict;
        endcase
    endfunction

    // Returns the edge index (first edge after the call = 0) at which the selected output rises.
    task automatic measure(input string name, input int sel, input int want);
        int got = -1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (out_sel(sel) === 1'b1) begin
                got = e;
                break;
            end
        end
        check(name, got, want);
    endtask

    task automatic set_inputs(input logic on, input logic off);
        @(negedge clk); #1;
        btn_on  = on;
        btn_off = off;
    endtask

    initial begin
        int seen;
        reset = 1'b0; btn_on = 1'b0; btn_off = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", int'({j, k, conflict}), 0);
        @(negedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);

        // Held set request: j after DB+2 edges
        set_inputs(1, 0);
        measure("on_latency", 0, DB + 2);
        check("on_k_low", int'(k), 0);
        check("on_conflict_low", int'(conflict), 0);

        // Clear request while set is active -> conflict
        set_inputs(1, 1);
        measure("conflict_latency", 2, DB + 2);
        check("conflict_jk_low", int'({j, k}), 0);
        set_inputs(0, 1);
`ifndef JK_PULSE_OUT_EN
        measure("k_after_on_release", 1, DB + 2);
`endif
        repeat (10) @(posedge clk);
        #1 check("conflict_cleared", int'(conflict), 0);
        set_inputs(0, 0);
        repeat (12) @(posedge clk);
        #1 check("idle_outputs", int'({j, k, conflict}), 0);

        // Glitch of three sampled clocks never reaches j
        set_inputs(1, 0);
        repeat (3) @(posedge clk);
        set_inputs(0, 0);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (j) seen = 1;
        end
        check("glitch_3clk", seen, 0);

        // Reset one edge before acceptance abandons the change; full latency after release
        set_inputs(1, 0);
        repeat (DB + 1) @(posedge clk);
        #2 reset = 1'b0;
        #1 check("reset_midcount", int'({j, k, conflict}), 0);
        @(negedge clk); #1 reset = 1'b1;
        measure("latency_after_reset", 0, DB + 2);
        set_inputs(1, 1);
        repeat (12) @(posedge clk);
        #1 check("both_held_conflict", int'({j, k, conflict}), 1);
        #1 reset = 1'b0;
        #1 check("reset_async_clear", int'({j, k, conflict}), 0);
        @(negedge clk); #1 reset = 1'b1; btn_on = 1'b0; btn_off = 1'b0;
        repeat (12) @(posedge clk);

`ifdef JK_PULSE_OUT_EN
        begin
            int jc = 0, kc = 0, first = -1;
            set_inputs(1, 0);
            for (int e = 0; e < 20; e++) begin
                @(posedge clk); #1;
                if (j) begin
                    jc++;
                    if (first < 0) first = e;
                end
                if (k) kc++;
            end
            set_inputs(0, 0);
            check("pulse_count", jc, 1);
            check("pulse_edge", first, DB + 2);
            check("pulse_no_k", kc, 0);
            repeat (12) @(posedge clk);
        end
`endif

        // Randomised holds, glitches and occasional resets against the model
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 99) < 4) begin
                @(negedge clk); #1 reset = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                @(negedge clk); #1 reset = 1'b1;
            end else begin
                set_inputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                repeat ($urandom_range(1, 12)) @(posedge clk);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
